// File: rtl/seg_pkg.sv
// Shared types, glyph codes and helpers for the multiplexed 7-segment output stage.
// Glyphs are active-low, bit 6..0 = segment g..a.
package seg_pkg;

  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_L     = 7'h47;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_D     = 7'h21;

  typedef enum logic [1:0] {
    MODE_UDEC = 2'd0,
    MODE_SDEC = 2'd1,
    MODE_HEX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seg_fsm_e;

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Decimal digits needed for any w-bit unsigned value: floor(w*log10(2)) + 1.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one iteration per clock.
// Keeps enough BCD digits for the full input range so overflow of the visible digits is exact.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W     = 26,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    ovf
);
  localparam int FULL_D = bcd_digits(DATA_W);
  localparam int BCD_D  = (FULL_D > NUM_DIGITS) ? FULL_D : NUM_DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic [BCD_D-1:0][3:0] acc, acc_adj;
  logic [DATA_W-1:0]     sr;
  logic [CNT_W-1:0]      cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_D; i++)
      if (acc[i] >= 4'd5) acc_adj[i] = acc[i] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      sr  <= bin;
      cnt <= CNT_W'(DATA_W);
    end else if (cnt != '0) begin
      {acc, sr} <= {acc_adj, sr} << 1;
      cnt       <= cnt - CNT_W'(1);
    end
  end

  // High during the final iteration: bcd/ovf are settled from the next cycle on.
  assign done = (cnt == CNT_W'(1));
  assign bcd  = acc[NUM_DIGITS-1:0];

  always_comb begin
    ovf = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_D; i++)
      ovf = ovf | (acc[i] != 4'd0);
  end

endmodule

// File: rtl/seg_display_scan.sv
// Bus-captured value -> decimal/hex digits -> time-multiplexed active-low 7-segment drive.
// Conversion runs in a small FSM around bin2bcd_seq; the scan uses a clock-enable tick in clk.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 26,
  parameter int BUS_W      = 32,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCAN_FREQ  = 8000
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  tri0 [BUS_W-1:0]       bus,
  input  logic                  OUT_read,
  input  logic                  print_load,
  input  logic [1:0]            mode,
  input  logic                  blank_lz,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  busy
);
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int TICK_MAX = CLK_FREQ / SCAN_FREQ - 1;
  localparam int TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int PAD_W    = NUM_DIGITS * 4 + DATA_W;

  typedef struct packed {
    logic                       ovf;
    logic                       neg;
    logic [NUM_DIGITS-1:0][3:0] nib;
  } frame_t;

  logic [DATA_W-1:0]       val_lat, mag, mag_q;
  mode_e                   mode_lat;
  logic                    pending;
  seg_fsm_e                state, state_nx;
  logic                    conv_start, conv_done, conv_ovf, conv_neg, conv_hex;
  logic [NUM_DIGITS*4-1:0] conv_bcd;
  logic [PAD_W-1:0]        hex_pad;
  logic                    hex_ovf, neg_ovf;
  frame_t                  frame;
  logic [TICK_W-1:0]       tick;
  logic [IDX_W-1:0]        idx, msnz;
  logic [IDX_W:0]          sign_pos;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_nx;

  if (BUS_W > DATA_W) begin : g_bus_hi
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus[BUS_W-1:DATA_W];
  end

  // Latest capture wins; pending is consumed when the FSM leaves IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_lat  <= '0;
      mode_lat <= MODE_UDEC;
      pending  <= 1'b0;
    end else if (OUT_read) begin
      val_lat  <= bus[DATA_W-1:0];
      mode_lat <= (mode == 2'd3) ? MODE_UDEC : mode_e'(mode);
      pending  <= 1'b1;
    end else if (state == S_IDLE) begin
      pending  <= 1'b0;
    end
  end

  assign mag = (mode_lat == MODE_SDEC && val_lat[DATA_W-1]) ? ~val_lat + DATA_W'(1) : val_lat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    conv_start = 1'b0;
    case (state)
      S_IDLE:  if (pending) state_nx = S_LOAD;
      S_LOAD: begin
        if (mode_lat == MODE_HEX) begin
          state_nx = S_DONE;
        end else begin
          conv_start = 1'b1;
          state_nx   = S_SHIFT;
        end
      end
      S_SHIFT: if (conv_done) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = pending | (state != S_IDLE);

  // Snapshot of the conversion in flight, so a capture mid-conversion cannot corrupt it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q    <= '0;
      conv_neg <= 1'b0;
      conv_hex <= 1'b0;
    end else if (state == S_LOAD) begin
      mag_q    <= mag;
      conv_neg <= (mode_lat == MODE_SDEC) && val_lat[DATA_W-1];
      conv_hex <= (mode_lat == MODE_HEX);
    end
  end

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  assign hex_pad = PAD_W'(mag_q);
  assign hex_ovf = |hex_pad[PAD_W-1:NUM_DIGITS*4];
  // A negative number also needs the leftmost digit free for its sign.
  assign neg_ovf = conv_neg && (conv_bcd[NUM_DIGITS*4-1 -: 4] != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame <= '0;
    end else if (state == S_DONE) begin
      if (conv_hex) begin
        frame.nib <= hex_pad[NUM_DIGITS*4-1:0];
        frame.neg <= 1'b0;
        frame.ovf <= hex_ovf;
      end else begin
        frame.nib <= conv_bcd;
        frame.neg <= conv_neg;
        frame.ovf <= conv_ovf | neg_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TICK_W'(TICK_MAX)) begin
      tick <= '0;
      idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  always_comb begin
    msnz = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (frame.nib[i] != 4'd0) msnz = IDX_W'(i);
    sign_pos = blank_lz ? (IDX_W+1)'(msnz) + (IDX_W+1)'(1) : (IDX_W+1)'(NUM_DIGITS - 1);
  end

  always_comb begin
    glyph = hex_to_glyph(frame.nib[idx]);
    an_nx = ~(NUM_DIGITS'(1) << idx);
    if (print_load) begin
      case (idx)
        IDX_W'(3): glyph = GLYPH_L;
        IDX_W'(2): glyph = GLYPH_O;
        IDX_W'(1): glyph = GLYPH_A;
        IDX_W'(0): glyph = GLYPH_D;
        default: begin
          glyph = GLYPH_BLANK;
          an_nx = '1;
        end
      endcase
    end else if (frame.ovf) begin
      glyph = GLYPH_DASH;
    end else if (frame.neg && ({1'b0, idx} == sign_pos)) begin
      glyph = GLYPH_DASH;
    end else if (blank_lz && (idx > msnz)) begin
      glyph = GLYPH_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      SEG <= GLYPH_BLANK;
      AN  <= '1;
    end else begin
      SEG <= glyph;
      AN  <= an_nx;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with a fast scan (10 clocks per digit).
module tb_seg_display_scan;
  localparam int ND = 8;
  localparam int DW = 26;
  localparam int BW = 32;
  localparam int CF = 80_000;
  localparam int SF = 8000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          OUT_read = 1'b0;
  logic          print_load = 1'b0;
  logic          blank_lz = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [BW-1:0] bus_val = '0;
  wire  [BW-1:0] bus;
  logic [6:0]    SEG;
  logic [ND-1:0] AN;
  logic          busy;
  int            n_chk = 0;
  int            n_fail = 0;

  assign bus = bus_val;
  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .BUS_W      (BW),
    .CLK_FREQ   (CF),
    .SCAN_FREQ  (SF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .OUT_read   (OUT_read),
    .print_load (print_load),
    .mode       (mode),
    .blank_lz   (blank_lz),
    .SEG        (SEG),
    .AN         (AN),
    .busy       (busy)
  );

  task automatic capture(input logic [BW-1:0] v, input logic [1:0] m);
    @(negedge clk);
    bus_val  = v;
    mode     = m;
    OUT_read = 1'b1;
    @(negedge clk);
    OUT_read = 1'b0;
  endtask

  // Returns the glyph shown on digit d, or X if that digit never lights in the window.
  task automatic read_digit(input int d, output logic [6:0] seg);
    logic [ND-1:0] want;
    bit            found;
    want  = ~(ND'(1) << d);
    seg   = 'x;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (AN === want) begin
        seg   = SEG;
        found = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    logic [6:0] s;
    logic [6:0] exp [ND];
    exp = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    #23;
    n_chk++; if (SEG !== 7'h7F) begin n_fail++; $display("FAIL reset SEG: got %h required 7f", SEG); end
    n_chk++; if (AN !== 8'hFF) begin n_fail++; $display("FAIL reset AN: got %h required ff", AN); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b required 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL reset_display digit %0d: got %h required %h", d, s, exp[d]); end
    end
  endtask

  task automatic test_scan();
    logic [ND-1:0] prev;
    int            cnt;
    bit            ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (AN === 8'h7F) ok = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (AN !== 8'h7F) ok = 1'b1; end
    n_chk++; if (AN !== 8'hFE) begin n_fail++; $display("FAIL scan wrap: got %h required fe", AN); end
    for (int k = 1; k <= ND; k++) begin
      prev = AN;
      cnt  = 0;
      do begin @(negedge clk); cnt++; end while (AN === prev && cnt < 50);
      n_chk++;
      if (cnt != 10) begin n_fail++; $display("FAIL scan dwell %0d: got %0d cycles required 10", k, cnt); end
      n_chk++;
      if (AN !== ~(ND'(1) << (k % ND))) begin
        n_fail++; $display("FAIL scan order %0d: got %h required %h", k, AN, ~(ND'(1) << (k % ND)));
      end
    end
  endtask

  task automatic test_unsigned();
    logic [6:0] s;
    logic [6:0] exp [ND];
    int         cnt;
    exp = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    blank_lz = 1'b1;
    capture(32'd12_345_678, 2'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_chk++; if (cnt != 29) begin n_fail++; $display("FAIL udec busy length: got %0d required 29", cnt); end
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL udec digit %0d: got %h required %h", d, s, exp[d]); end
    end
  endtask

  task automatic test_signed();
    logic [6:0] s;
    logic [6:0] exp [ND];
    exp = '{7'h30, 7'h24, 7'h79, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    blank_lz = 1'b1;
    capture(32'h03FF_FF85, 2'd1);
    wait_idle("sdec");
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL sdec digit %0d: got %h required %h", d, s, exp[d]); end
    end
  endtask

  task automatic test_hex();
    logic [6:0] s;
    logic [6:0] exp [ND];
    int         cnt;
    exp = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h24, 7'h7F};
    blank_lz = 1'b1;
    capture(32'h02AD_BEEF, 2'd2);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    n_chk++; if (cnt != 3) begin n_fail++; $display("FAIL hex busy length: got %0d required 3", cnt); end
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL hex digit %0d: got %h required %h", d, s, exp[d]); end
    end
  endtask

  task automatic test_no_blank();
    logic [6:0] s;
    logic [6:0] exp [ND];
    blank_lz = 1'b0;
    exp = '{7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F};
    capture(32'((1 << DW) - 5), 2'd1);
    wait_idle("noblank_neg");
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL noblank_neg digit %0d: got %h required %h", d, s, exp[d]); end
    end
    exp = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    capture(32'd42, 2'd3);
    wait_idle("mode3");
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL mode3 digit %0d: got %h required %h", d, s, exp[d]); end
    end
    blank_lz = 1'b1;
  endtask

  task automatic test_overflow();
    logic [6:0] s;
    logic [6:0] exp [ND];
    blank_lz = 1'b1;
    capture(32'((1 << DW) - 10_000_000), 2'd1);
    wait_idle("ovf");
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== 7'h3F) begin n_fail++; $display("FAIL ovf digit %0d: got %h required 3f", d, s); end
    end
    exp = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h3F};
    capture(32'((1 << DW) - 9_999_999), 2'd1);
    wait_idle("ovf_edge");
    for (int d = 0; d < ND; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL ovf_edge digit %0d: got %h required %h", d, s, exp[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    blank_lz = 1'b1;
    capture(32'd42, 2'd0);
    @(negedge clk);
    capture(32'd7, 2'd0);
    wait_idle("b2b");
    read_digit(0, s);
    n_chk++; if (s !== 7'h78) begin n_fail++; $display("FAIL b2b digit 0: got %h required 78", s); end
    read_digit(1, s);
    n_chk++; if (s !== 7'h7F) begin n_fail++; $display("FAIL b2b digit 1: got %h required 7f", s); end
  endtask

  task automatic test_print_load();
    logic [6:0] s;
    logic [6:0] exp [4];
    int         bad;
    exp = '{7'h21, 7'h08, 7'h40, 7'h47};
    @(negedge clk);
    print_load = 1'b1;
    capture(32'd12_345_678, 2'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (AN[7:4] !== 4'hF) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL load_an_high: got %0d low samples required 0", bad); end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s);
      n_chk++;
      if (s !== exp[d]) begin n_fail++; $display("FAIL load digit %0d: got %h required %h", d, s, exp[d]); end
    end
    print_load = 1'b0;
    wait_idle("load_bg");
    read_digit(7, s);
    n_chk++; if (s !== 7'h79) begin n_fail++; $display("FAIL load_bg digit 7: got %h required 79", s); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    capture(32'd999, 2'd0);
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b required 0", busy); end
    n_chk++; if (SEG !== 7'h7F) begin n_fail++; $display("FAIL midreset SEG: got %h required 7f", SEG); end
    n_chk++; if (AN !== 8'hFF) begin n_fail++; $display("FAIL midreset AN: got %h required ff", AN); end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset restart: busy=%b required 0", busy); end
    read_digit(0, s);
    n_chk++; if (s !== 7'h40) begin n_fail++; $display("FAIL midreset digit 0: got %h required 40", s); end
    read_digit(2, s);
    n_chk++; if (s !== 7'h7F) begin n_fail++; $display("FAIL midreset digit 2: got %h required 7f", s); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_unsigned();
    test_signed();
    test_hex();
    test_no_blank();
    test_overflow();
    test_back_to_back();
    test_print_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
